// File: rtl/timer_event_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : timer_event_ctrl
//  Description : Event post-processor for the saturating up/down counter.
//                Timestamps timer events into a capture FIFO, keeps a
//                saturating event count, drives a level interrupt with an
//                acknowledge/hold-off handshake and, optionally, emits an
//                auto-reload pulse back to the counter.
//  Build macro : TIMER_EVT_AUTORELOAD_EN - builds the auto-reload path;
//                when undefined reload/reload_din are tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_event_ctrl #(
  parameter int DEPTH  = 4,
  parameter int ECNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              timer_event,
  input  logic [31:0]       count,
  input  logic              irq_en,
  input  logic              irq_ack,
  input  logic              clear,
  input  logic              snap_ready,
  input  logic [31:0]       reload_val,
  output logic              irq,
  output logic              pending,
  output logic [ECNT_W-1:0] event_cnt,
  output logic              overflow,
  output logic              snap_valid,
  output logic [31:0]       snap_data,
  output logic              reload,
  output logic [31:0]       reload_din
);

  localparam int               c_AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_AW:0]    c_OCC_FULL = (c_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_HOLDOFF = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_irq;
  logic              r_pending;
  logic [ECNT_W-1:0] r_event_cnt;
  logic              r_overflow;
  logic              r_snap_valid;
  logic [31:0]       r_mem [DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_AW:0]     r_occ;

  logic              w_ev;
  logic              w_full;
  logic              w_pop;
  logic              w_push_ok;
  logic              w_drop;
  logic [c_AW:0]     w_occ_nxt;

  // An event coinciding with clear is discarded everywhere.
  assign w_ev      = timer_event && !clear;
  assign w_full    = (r_occ == c_OCC_FULL);
  assign w_pop     = r_snap_valid && snap_ready && !clear;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push_ok = w_ev && (!w_full || w_pop);
  assign w_drop    = w_ev && w_full && !w_pop;

  // Next FIFO occupancy; snap_valid is registered from it so it stays a flop.
  always_comb begin
    w_occ_nxt = r_occ;
    if (clear) begin
      w_occ_nxt = '0;
    end else if (w_push_ok && !w_pop) begin
      w_occ_nxt = r_occ + 1'b1;
    end else if (!w_push_ok && w_pop) begin
      w_occ_nxt = r_occ - 1'b1;
    end
  end

  // Capture FIFO storage, pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_occ        <= '0;
      r_snap_valid <= 1'b0;
      r_overflow   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_occ        <= w_occ_nxt;
      r_snap_valid <= (w_occ_nxt != '0);
      if (clear) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_push_ok) begin
          r_mem[r_wr_ptr] <= count;
          r_wr_ptr        <= r_wr_ptr + 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        if (w_drop) begin
          r_overflow <= 1'b1;
        end
      end
    end
  end

  // Saturating event counter; holds at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_event_cnt <= '0;
    end else if (w_ev && (r_event_cnt != '1)) begin
      r_event_cnt <= r_event_cnt + 1'b1;
    end
  end

  // Interrupt FSM with registered irq; clear only drops pending, not state.
  always_ff @(posedge clk) begin
    if (reset || !irq_en) begin
      r_state   <= S_IDLE;
      r_irq     <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_pending <= 1'b0;
          if (w_ev) begin
            r_state <= S_ASSERT;
            r_irq   <= 1'b1;
          end
        end
        S_ASSERT: begin
          if (w_ev) begin
            r_pending <= 1'b1;
          end else if (clear) begin
            r_pending <= 1'b0;
          end
          if (irq_ack) begin
            r_state <= S_HOLDOFF;
            r_irq   <= 1'b0;
          end
        end
        S_HOLDOFF: begin
          // A clear in this cycle wipes the pending request before it is used.
          r_pending <= 1'b0;
          if (!clear && (r_pending || w_ev)) begin
            r_state <= S_ASSERT;
            r_irq   <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_irq   <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_irq     <= 1'b0;
          r_pending <= 1'b0;
        end
      endcase
    end
  end

`ifdef TIMER_EVT_AUTORELOAD_EN
  logic        r_reload;
  logic [31:0] r_reload_din;

  // One-cycle reload pulse per accepted event, value captured with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_reload     <= 1'b0;
      r_reload_din <= '0;
    end else begin
      r_reload <= w_ev;
      if (w_ev) begin
        r_reload_din <= reload_val;
      end
    end
  end

  assign reload     = r_reload;
  assign reload_din = r_reload_din;
`else
  logic w_unused_reload;
  assign w_unused_reload = ^reload_val;
  assign reload          = 1'b0;
  assign reload_din      = '0;
`endif

  assign irq        = r_irq;
  assign pending    = r_pending;
  assign event_cnt  = r_event_cnt;
  assign overflow   = r_overflow;
  assign snap_valid = r_snap_valid;
  assign snap_data  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_timer_event_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_event_ctrl
//  Description : Randomised scoreboard bench for timer_event_ctrl against a
//                queue-based behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_event_ctrl;

  localparam int DEPTH  = 4;
  localparam int ECNT_W = 16;
  localparam int M_IDLE = 0, M_ASSERT = 1, M_HOLD = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              timer_event = 1'b0;
  logic [31:0]       count = '0;
  logic              irq_en = 1'b0;
  logic              irq_ack = 1'b0;
  logic              clear = 1'b0;
  logic              snap_ready = 1'b0;
  logic [31:0]       reload_val = '0;
  logic              irq;
  logic              pending;
  logic [ECNT_W-1:0] event_cnt;
  logic              overflow;
  logic              snap_valid;
  logic [31:0]       snap_data;
  logic              reload;
  logic [31:0]       reload_din;

  always #5 clk = ~clk;

  timer_event_ctrl #(.DEPTH(DEPTH), .ECNT_W(ECNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .timer_event(timer_event),
    .count      (count),
    .irq_en     (irq_en),
    .irq_ack    (irq_ack),
    .clear      (clear),
    .snap_ready (snap_ready),
    .reload_val (reload_val),
    .irq        (irq),
    .pending    (pending),
    .event_cnt  (event_cnt),
    .overflow   (overflow),
    .snap_valid (snap_valid),
    .snap_data  (snap_data),
    .reload     (reload),
    .reload_din (reload_din)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected timestamps, popped by the monitor as the DUT hands them out.
  logic [31:0] sb_q[$];
  // Reference model state.
  logic [31:0] m_q[$];
  int          m_mode = M_IDLE;
  bit          m_pend = 0;
  bit          m_ovf  = 0;
  bit          m_rel  = 0;
  int          m_ecnt = 0;
  logic [31:0] m_rdin = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every DUT pop must deliver the oldest expected timestamp.
  always @(negedge clk) begin
    if (snap_valid && snap_ready && !reset && !clear) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL snap_extra: got valid data 0x%08h expected nothing at %0t", snap_data, $time);
      end else begin
        chk("snap_data", snap_data, sb_q.pop_front());
      end
    end
  end

  // Drive one cycle of inputs, advance the model, then check after the edge.
  task automatic step(input bit rst, input bit ev, input logic [31:0] cnt, input bit en,
                      input bit ack, input bit clr, input bit rdy, input logic [31:0] rv);
    bit acc;
    reset = rst; timer_event = ev; count = cnt; irq_en = en;
    irq_ack = ack; clear = clr; snap_ready = rdy; reload_val = rv;
    acc = ev && !clr;
    if (rst) begin
      m_mode = M_IDLE; m_pend = 0; m_ovf = 0; m_ecnt = 0; m_rel = 0; m_rdin = '0;
      m_q.delete(); sb_q.delete();
    end else begin
      if (clr) begin
        m_ecnt = 0; m_ovf = 0; m_pend = 0;
        m_q.delete(); sb_q.delete();
      end else begin
        if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
        if (acc) begin
          if (m_ecnt < (2**ECNT_W) - 1) m_ecnt++;
          if (m_q.size() < DEPTH) begin
            m_q.push_back(cnt);
            sb_q.push_back(cnt);
          end else begin
            m_ovf = 1;
          end
        end
      end
      if (!en) begin
        m_mode = M_IDLE; m_pend = 0;
      end else begin
        case (m_mode)
          M_IDLE:   if (acc) m_mode = M_ASSERT;
          M_ASSERT: begin
            if (acc) m_pend = 1;
            if (ack) m_mode = M_HOLD;
          end
          default: begin
            m_mode = (m_pend || acc) ? M_ASSERT : M_IDLE;
            m_pend = 0;
          end
        endcase
      end
`ifdef TIMER_EVT_AUTORELOAD_EN
      m_rel = acc;
      if (acc) m_rdin = rv;
`else
      m_rel = 0;
      m_rdin = '0;
`endif
    end
    @(posedge clk);
    #1;
    chk("irq", 32'(irq), 32'(m_mode == M_ASSERT));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("event_cnt", 32'(event_cnt), 32'(m_ecnt));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("snap_valid", 32'(snap_valid), 32'(m_q.size() != 0));
    chk("reload", 32'(reload), 32'(m_rel));
    chk("reload_din", reload_din, m_rdin);
  endtask

  initial begin
    // Reset
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_snap_data", snap_data, 32'h0);

    // Single event then one pop
    step(0, 1, 32'h64, 1, 0, 0, 0, 0);
    chk("t1_head", snap_data, 32'h64);
    step(0, 0, 0, 1, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);

    // Overflow with five events into a four-entry FIFO, then clear
    for (int i = 1; i <= 5; i++) step(0, 1, 32'(i), 1, 0, 0, 0, 0);
    chk("t2_head", snap_data, 32'h1);
    step(0, 0, 0, 1, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);

    // irq 1,0,1 via pending, then a plain ack back to idle
    step(0, 1, 32'hA0, 1, 0, 0, 1, 0);
    step(0, 1, 32'hA1, 1, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 1, 0);

    // Full FIFO with simultaneous push and pop, then drain
    step(0, 0, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 32'h200 + 32'(i), 1, 0, 0, 0, 0);
    step(0, 1, 32'h204, 1, 0, 0, 1, 0);
    chk("t4_head", snap_data, 32'h201);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1, 0, 1, 0);

    // Saturation of the event counter
    step(0, 0, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 32'hFFFE + 3; i++)
      step(0, 1, 32'(i), 1, ($urandom_range(3) == 0), 0, $urandom_range(1), 0);
    chk("t5_sat", 32'(event_cnt), 32'hFFFF);

    // Auto-reload pulse
    step(0, 1, 32'h77, 1, 0, 0, 1, 32'h1000);
    step(0, 0, 0, 1, 0, 0, 1, 32'h2000);

    // Randomised traffic
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(199) == 0), $urandom_range(1), $urandom,
           ($urandom_range(7) != 0), ($urandom_range(3) == 0),
           ($urandom_range(39) == 0), $urandom_range(1), $urandom);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
